mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 144 ++++++++++++++
 tb/tb_mem_stage.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
//
// Memory-access pipeline stage.
//
// The stage takes one instruction from execute, collects the load data that the
// synchronous data SRAM returns, and offers the result to writeback. It also
// drives a forwarding bus back to decode.
//
// Optional feature (compile-time macro MEM_LOAD_EXT_EN):
//   defined   - LD.B / LD.BU / LD.H / LD.HU sub-word extraction and extension,
//               selected by ld_type and addr_lo.
//   undefined - ld_type and addr_lo are ignored and every load returns the full
//               32-bit word.
//   Bus widths are the same in both builds.
//
// Ports:
//   clk              in   1   clock; all state changes on the rising edge
//   reset            in   1   synchronous, active-high reset
//   ws_allowin       in   1   writeback can accept an instruction this cycle
//   ms_allowin       out  1   this stage can accept an instruction this cycle
//   es_to_ms_valid   in   1   execute presents a valid instruction
//   es_to_ms_bus     in   76  {ld_type[75:73], addr_lo[72:71], res_from_mem[70],
//                             gr_we[69], dest[68:64], alu_result[63:32], pc[31:0]}
//   ms_to_ws_valid   out  1   valid instruction offered to writeback
//   ms_to_ws_bus     out  70  {gr_we[69], dest[68:64], final_result[63:32], pc[31:0]}
//   data_sram_rdata  in   32  SRAM read data, valid only in the first cycle
//                             after the request
//   ms_to_ds_bus     out  39  {ms_we[38], dest[37:33], final_result[32:1],
//                             ms_is_load[0]}
// -----------------------------------------------------------------------------
module mem_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        ws_allowin,
    output logic        ms_allowin,
    input  logic        es_to_ms_valid,
    input  logic [75:0] es_to_ms_bus,
    output logic        ms_to_ws_valid,
    output logic [69:0] ms_to_ws_bus,
    input  logic [31:0] data_sram_rdata,
    output logic [38:0] ms_to_ds_bus
);

    logic        ms_valid;
    logic        ms_ready_go;
    logic [75:0] es_to_ms_bus_r;
    logic        rdata_held;
    logic [31:0] rdata_hold;

    logic [2:0]  ld_type;
    logic [1:0]  addr_lo;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;

    logic        accept;
    logic        ms_valid_next;
    logic        hold_set;
    logic        hold_clr;
    logic [31:0] raw_rdata;
    logic [31:0] load_data;
    logic [31:0] final_result;

    assign {ld_type, addr_lo, res_from_mem, gr_we, dest, alu_result, pc} = es_to_ms_bus_r;

    assign ms_ready_go    = 1'b1;
    assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid && ms_ready_go;

    assign accept        = es_to_ms_valid && ms_allowin;
    assign ms_valid_next = ms_allowin ? es_to_ms_valid : ms_valid;

    // The SRAM presents read data for a single cycle only. If writeback stalls
    // us during that cycle the word must be captured, or it is lost.
    assign hold_set = ms_valid && res_from_mem && !rdata_held && !ws_allowin;
    // A new instruction or an emptied stage invalidates whatever was held, so a
    // back-to-back load never sees its predecessor's data.
    assign hold_clr = accept || !ms_valid_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid   <= 1'b0;
            rdata_held <= 1'b0;
        end else begin
            if (ms_allowin) begin
                ms_valid <= es_to_ms_valid;
            end
            if (accept) begin
                es_to_ms_bus_r <= es_to_ms_bus;
            end
            if (hold_clr) begin
                rdata_held <= 1'b0;
            end else if (hold_set) begin
                rdata_held <= 1'b1;
                rdata_hold <= data_sram_rdata;
            end
        end
    end

    assign raw_rdata = rdata_held ? rdata_hold : data_sram_rdata;

`ifdef MEM_LOAD_EXT_EN
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = raw_rdata[7:0];
        case (addr_lo)
            2'd0:    byte_sel = raw_rdata[7:0];
            2'd1:    byte_sel = raw_rdata[15:8];
            2'd2:    byte_sel = raw_rdata[23:16];
            default: byte_sel = raw_rdata[31:24];
        endcase
    end

    // Halfword lane is picked by addr_lo[1]; an odd address is not flagged here.
    assign half_sel = addr_lo[1] ? raw_rdata[31:16] : raw_rdata[15:0];

    always_comb begin
        load_data = raw_rdata;
        case (ld_type)
            3'b001:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b011:  load_data = {24'd0, byte_sel};
            3'b010:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_data = {16'd0, half_sel};
            default: load_data = raw_rdata;
        endcase
    end
`else
    // Sub-word fields are carried on the bus but have no consumer in this build.
    logic unused_ld_fields;
    assign unused_ld_fields = ^{ld_type, addr_lo};
    assign load_data        = raw_rdata;
`endif

    assign final_result = res_from_mem ? load_data : alu_result;

    assign ms_to_ws_bus = {gr_we, dest, final_result, pc};
    assign ms_to_ds_bus = {ms_valid && gr_we, dest, final_result, ms_valid && res_from_mem};

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    logic        clk;
    logic        reset;
    logic        ws_allowin;
    logic        ms_allowin;
    logic        es_to_ms_valid;
    logic [75:0] es_to_ms_bus;
    logic        ms_to_ws_valid;
    logic [69:0] ms_to_ws_bus;
    logic [31:0] data_sram_rdata;
    logic [38:0] ms_to_ds_bus;

    int errors = 0;
    int checks = 0;

    mem_stage dut (
        .clk             (clk),
        .reset           (reset),
        .ws_allowin      (ws_allowin),
        .ms_allowin      (ms_allowin),
        .es_to_ms_valid  (es_to_ms_valid),
        .es_to_ms_bus    (es_to_ms_bus),
        .ms_to_ws_valid  (ms_to_ws_valid),
        .ms_to_ws_bus    (ms_to_ws_bus),
        .data_sram_rdata (data_sram_rdata),
        .ms_to_ds_bus    (ms_to_ds_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [69:0] got, input logic [69:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [75:0] mk_bus(input logic [2:0] ld, input logic [1:0] al,
                                           input logic rfm, input logic we,
                                           input logic [4:0] dst, input logic [31:0] alu,
                                           input logic [31:0] pc);
        return {ld, al, rfm, we, dst, alu, pc};
    endfunction

    // Present one instruction for one cycle; returns at the negedge of the
    // cycle in which it sits in the mem stage.
    task automatic issue(input logic [75:0] bus);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = bus;
        @(negedge clk);
        es_to_ms_valid = 1'b0;
        es_to_ms_bus   = '0;
    endtask

    task automatic run_load(input string tag, input logic [2:0] ld, input logic [1:0] al,
                            input logic [31:0] rd, input logic [31:0] exp);
        ws_allowin = 1'b1;
        issue(mk_bus(ld, al, 1'b1, 1'b1, 5'd7, 32'h0000_0100, 32'h1c00_0040));
        data_sram_rdata = rd;
        #1;
        chk(tag, {38'd0, ms_to_ws_bus[63:32]}, {38'd0, exp});
        @(negedge clk);
        data_sram_rdata = 32'h0;
    endtask

    initial begin
        reset           = 1'b1;
        ws_allowin      = 1'b1;
        es_to_ms_valid  = 1'b0;
        es_to_ms_bus    = '0;
        data_sram_rdata = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ws_valid", {69'd0, ms_to_ws_valid}, 70'd0);
        chk("rst_allowin",  {69'd0, ms_allowin},     70'd1);
        chk("rst_ds_we",    {69'd0, ms_to_ds_bus[38]}, 70'd0);
        chk("rst_ds_load",  {69'd0, ms_to_ds_bus[0]},  70'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // LD.W, writeback ready: offered for exactly one cycle
        issue(mk_bus(3'b000, 2'd0, 1'b1, 1'b1, 5'd3, 32'h0000_1000, 32'h1c00_0000));
        data_sram_rdata = 32'h8765_4321;
        #1;
        chk("ldw_valid",  {69'd0, ms_to_ws_valid}, 70'd1);
        chk("ldw_ws_bus", ms_to_ws_bus, {1'b1, 5'd3, 32'h8765_4321, 32'h1c00_0000});
        chk("ldw_ds_bus", {31'd0, ms_to_ds_bus}, {31'd0, 1'b1, 5'd3, 32'h8765_4321, 1'b1});
        @(negedge clk);
        data_sram_rdata = 32'hAAAA_AAAA;
        #1;
        chk("ldw_valid_gone", {69'd0, ms_to_ws_valid}, 70'd0);
        chk("ldw_ds_load_gone", {69'd0, ms_to_ds_bus[0]}, 70'd0);
        @(negedge clk);

`ifdef MEM_LOAD_EXT_EN
        run_load("ldb_a2",  3'b001, 2'd2, 32'h80FF_7F01, 32'hFFFF_FFFF);
        run_load("ldb_a1",  3'b001, 2'd1, 32'h80FF_7F01, 32'h0000_007F);
        run_load("ldbu_a3", 3'b011, 2'd3, 32'h80FF_7F01, 32'h0000_0080);
        run_load("ldh_a2",  3'b010, 2'd2, 32'h80FF_7F01, 32'hFFFF_80FF);
        run_load("ldh_a3",  3'b010, 2'd3, 32'h80FF_7F01, 32'hFFFF_80FF);
        run_load("ldhu_a0", 3'b100, 2'd0, 32'h80FF_7F01, 32'h0000_7F01);
        run_load("ld_other",3'b111, 2'd1, 32'h80FF_7F01, 32'h80FF_7F01);
`else
        run_load("ldb_a2",  3'b001, 2'd2, 32'h80FF_7F01, 32'h80FF_7F01);
        run_load("ldbu_a3", 3'b011, 2'd3, 32'h80FF_7F01, 32'h80FF_7F01);
        run_load("ldh_a2",  3'b010, 2'd2, 32'h80FF_7F01, 32'h80FF_7F01);
        run_load("ldhu_a0", 3'b100, 2'd0, 32'h80FF_7F01, 32'h80FF_7F01);
`endif

        // LD.W stalled three cycles: first-cycle rdata must be held
        issue(mk_bus(3'b000, 2'd0, 1'b1, 1'b1, 5'd9, 32'h0000_2000, 32'h1c00_0080));
        ws_allowin      = 1'b0;
        data_sram_rdata = 32'h1234_5678;
        #1;
        chk("stall0_res",     {38'd0, ms_to_ws_bus[63:32]}, {38'd0, 32'h1234_5678});
        chk("stall0_allowin", {69'd0, ms_allowin}, 70'd0);
        for (int i = 1; i < 3; i++) begin
            @(negedge clk);
            data_sram_rdata = 32'hDEAD_BEEF;
            #1;
            chk($sformatf("stall%0d_res", i), {38'd0, ms_to_ws_bus[63:32]}, {38'd0, 32'h1234_5678});
            chk($sformatf("stall%0d_allowin", i), {69'd0, ms_allowin}, 70'd0);
            chk($sformatf("stall%0d_valid", i), {69'd0, ms_to_ws_valid}, 70'd1);
        end
        // writeback frees up; a new load enters in the same cycle
        @(negedge clk);
        ws_allowin = 1'b1;
        #1;
        chk("release_res",     {38'd0, ms_to_ws_bus[63:32]}, {38'd0, 32'h1234_5678});
        chk("release_allowin", {69'd0, ms_allowin}, 70'd1);
        issue(mk_bus(3'b000, 2'd0, 1'b1, 1'b1, 5'd10, 32'h0000_3000, 32'h1c00_0084));
        data_sram_rdata = 32'hCAFE_F00D;
        #1;
        chk("b2b_valid", {69'd0, ms_to_ws_valid}, 70'd1);
        chk("b2b_ws_bus", ms_to_ws_bus, {1'b1, 5'd10, 32'hCAFE_F00D, 32'h1c00_0084});
        @(negedge clk);

        // non-load forwarding
        issue(mk_bus(3'b000, 2'd0, 1'b0, 1'b1, 5'd5, 32'h0000_0010, 32'h1c00_0100));
        data_sram_rdata = 32'h5555_5555;
        #1;
        chk("alu_ds_bus", {31'd0, ms_to_ds_bus}, {31'd0, 1'b1, 5'd5, 32'h0000_0010, 1'b0});
        @(negedge clk);
        #1;
        chk("alu_ds_we_gone", {69'd0, ms_to_ds_bus[38]}, 70'd0);
        @(negedge clk);

        // reset during a held-load stall
        issue(mk_bus(3'b000, 2'd0, 1'b1, 1'b1, 5'd12, 32'h0000_4000, 32'h1c00_0200));
        ws_allowin      = 1'b0;
        data_sram_rdata = 32'h1111_1111;
        @(negedge clk);
        data_sram_rdata = 32'h3333_3333;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_stall_valid",   {69'd0, ms_to_ws_valid}, 70'd0);
        chk("rst_stall_allowin", {69'd0, ms_allowin}, 70'd1);
        chk("rst_stall_held",    {69'd0, dut.rdata_held}, 70'd0);
        @(negedge clk);
        ws_allowin = 1'b1;
        issue(mk_bus(3'b000, 2'd0, 1'b1, 1'b1, 5'd13, 32'h0000_5000, 32'h1c00_0204));
        data_sram_rdata = 32'h2222_2222;
        #1;
        chk("post_rst_fresh", {38'd0, ms_to_ws_bus[63:32]}, {38'd0, 32'h2222_2222});
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
